// File: rtl/icg_wake_seq.sv
// Per-channel clock-gate wake sequencer: OFF/WAKE/ON FSM per channel with idle timeout,
// and a round-robin wake grant so at most one gated clock starts per cycle.
module icg_wake_seq #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned WAKE_CYC = 2,
    parameter int unsigned IDLE_CYC = 16
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           TE,
    input  logic [NCH-1:0] REQ,
    output logic [NCH-1:0] E,
    output logic [NCH-1:0] ACK,
    output logic           BUSY
);

    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_WAKE = 2'd1,
        S_ON   = 2'd2
    } state_e;

    state_e         state_q [NCH];
    state_e         state_d [NCH];
    logic [7:0]     cnt_q   [NCH];
    logic [7:0]     cnt_d   [NCH];
    logic [PW-1:0]  ptr_q;
    logic [PW-1:0]  ptr_d;

    logic           gnt_vld;
    logic [PW-1:0]  gnt_idx;
    logic [CW-1:0]  cand;

    // Round-robin search over OFF channels requesting a wake, starting at ptr_q.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            cand = {1'b0, ptr_q} + CW'(k);
            if (cand >= CW'(NCH)) begin
                cand = cand - CW'(NCH);
            end
            if (!gnt_vld && (state_q[cand[PW-1:0]] == S_OFF) && REQ[cand[PW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld) begin
            if (gnt_idx == PW'(NCH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + PW'(1);
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                S_OFF: begin
                    if (gnt_vld && (gnt_idx == PW'(i))) begin
                        state_d[i] = S_WAKE;
                        cnt_d[i]   = 8'(WAKE_CYC - 1);
                    end
                end
                S_WAKE: begin
                    if (cnt_q[i] == 8'd0) begin
                        state_d[i] = S_ON;
                        cnt_d[i]   = 8'(IDLE_CYC - 1);
                    end else begin
                        cnt_d[i] = cnt_q[i] - 8'd1;
                    end
                end
                S_ON: begin
                    // A request on the expiry edge still wins over gating off.
                    if (REQ[i]) begin
                        cnt_d[i] = 8'(IDLE_CYC - 1);
                    end else if (cnt_q[i] == 8'd0) begin
                        state_d[i] = S_OFF;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 8'd1;
                    end
                end
                default: begin
                    state_d[i] = S_OFF;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= S_OFF;
                cnt_q[i]   <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        E    = '0;
        ACK  = '0;
        BUSY = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            E[i]   = (state_q[i] != S_OFF) | TE;
            ACK[i] = (state_q[i] == S_ON);
            BUSY   = BUSY | (state_q[i] == S_WAKE);
        end
    end

endmodule

// File: doc/icg_wake_seq.md
ICG_WAKE_SEQ -- requirements
Module: icg_wake_seq

Interface
REQ-001 Parameter NCH, default 4, number of gated clock channels (2..8).
REQ-002 Parameter WAKE_CYC, default 2, clock-settle cycles between enable and acknowledge (1..15).
REQ-003 Parameter IDLE_CYC, default 16, idle cycles before a channel's clock is gated off (1..255).
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 RST  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-006 TE  input  1  test enable; forces every E output high.
REQ-007 REQ  input  NCH  per-channel activity request, sampled on rising CLK.
REQ-008 E  output  NCH  per-channel enable to a negative-edge integrated clock gate.
REQ-009 ACK  output  NCH  per-channel "gated clock running and settled".
REQ-010 BUSY  output  1  high while any channel is in WAKE.

Function
REQ-011 Each channel SHALL run an independent FSM with states OFF, WAKE and ON, plus an 8-bit down-counter CNT.
REQ-012 E[i] SHALL be (state != OFF) OR TE; ACK[i] SHALL be (state == ON); TE SHALL NOT alter any FSM, counter or ACK.
REQ-013 OFF->WAKE SHALL occur only when REQ[i]=1 and channel i holds the wake grant; entry loads CNT=WAKE_CYC-1.
REQ-014 Wake grant: at most one channel SHALL leave OFF per rising edge (inrush limit), chosen round-robin among channels in OFF with REQ=1.
REQ-015 Round-robin search SHALL start at PTR; after a grant to channel g, PTR SHALL become (g+1) mod NCH; PTR is unchanged when there is no grant.
REQ-016 WAKE: if CNT==0 go to ON and load CNT=IDLE_CYC-1, else decrement CNT; REQ is ignored in WAKE, so a wake always completes.
REQ-017 Latency: REQ[i] sampled high at edge k with grant -> E[i]=1 after edge k, ACK[i]=1 after edge k+WAKE_CYC.
REQ-018 ON: REQ[i]=1 reloads CNT=IDLE_CYC-1; REQ[i]=0 with CNT==0 goes to OFF; otherwise CNT decrements.
REQ-019 Gate-off timing: after the last edge sampling REQ[i]=1 in ON, ACK[i] and E[i] SHALL fall after exactly IDLE_CYC further edges with REQ[i]=0.
REQ-020 A REQ[i] reassertion on any idle edge, including the one where CNT==0, SHALL reload CNT and keep the channel ON.
REQ-021 Re-entry: a channel returning to OFF SHALL be eligible for a grant on the very next edge.
REQ-022 BUSY SHALL be the OR of (state==WAKE) over all channels, combinational from state.
REQ-023 All transitions SHALL occur on rising CLK only; outputs SHALL be glitch-free functions of registered state, except for the TE OR term.

Reset
REQ-024 While RST=1, asynchronously: all channels OFF, CNT=0, PTR=0, ACK=0, BUSY=0, E=TE replicated.
REQ-025 RST asserted during WAKE or ON SHALL abort the channel immediately to OFF with no completion of the wake.
REQ-026 After RST deasserts, the first edge sampling REQ=1 SHALL grant per REQ-014, with PTR=0.

Verification
REQ-027 Defaults, RST released, REQ=0001 held from edge 1 -> E[0]=1 after edge 1, BUSY=1 after edges 1-2, ACK[0]=1 after edge 3.
REQ-028 Defaults, REQ=0101 raised together at edge 1 -> ch0 granted at edge 1, ch2 at edge 2; ACK[0] after edge 3, ACK[2] after edge 4; PTR=3.
REQ-029 Ch0 ON, REQ[0] low from edge 10 -> ACK[0]/E[0] fall after edge 25; a repeat run with one REQ[0] pulse sampled at edge 20 delays the fall to edge 36.
REQ-030 Ch1 in WAKE (after edge 5), RST pulsed between edges -> E[1], ACK[1], BUSY drop at once; no ACK[1] ever appears without a new REQ.
REQ-031 TE=1 with all channels OFF -> E=1111, ACK=0000, BUSY=0; FSMs do not move until REQ is asserted.
REQ-032 All four REQ held high for 8 edges -> grants in order 0,1,2,3, one per edge; BUSY stays 1 for edges 1-5, then all ACK=1.
